uart_tx: RTL

Simple UART transmitter with a small input FIFO, fixed 8n1 framing, LSB first. It accepts bytes on a valid/ready handshake, buffers them, and serializes each as one start bit, eight data bits and one stop bit on an idle-high line. It is the transmit half of the design's serial link and uses the same `CLKS_PER_BIT` bit-period convention as the receive side.

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer offers a byte with valid; the FIFO side answers with ready.
interface uart_tx_if;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;

  modport master (
    output i_tx_valid,
    output i_tx_data,
    input  o_tx_ready
  );

  modport slave (
    input  i_tx_valid,
    input  i_tx_data,
    output o_tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// 8n1 UART transmitter, LSB first, fed by a small byte FIFO.
// Idle-high line; back-to-back frames are contiguous.
module uart_tx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx,
  output logic      o_tx_busy,
  output logic      o_tx_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic cnt_zero;
  logic stop_avail;
  logic [7:0] pop_data;

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign tx.o_tx_ready = !full;
  assign push          = tx.i_tx_valid && !full;
  assign cnt_zero      = (cyc == '0);

  // The stop bit may hand over a byte pushed on this very edge.
  assign stop_avail = !empty || push;
  assign pop_data   = empty ? tx.i_tx_data : mem[rd_ptr];

  assign pop = ((state == IDLE) && !empty) ||
               ((state == STOP) && cnt_zero && stop_avail);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx.i_tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      o_tx_data <= 1'b1;
      o_tx_busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            shift     <= mem[rd_ptr];
            cyc       <= CNT_LOAD;
            state     <= START;
            o_tx_data <= 1'b0;
            o_tx_busy <= 1'b1;
          end else begin
            o_tx_data <= 1'b1;
            o_tx_busy <= (count_nxt != '0);
          end
        end
        START: begin
          o_tx_busy <= 1'b1;
          if (cnt_zero) begin
            cyc       <= CNT_LOAD;
            bit_idx   <= '0;
            state     <= DATA;
            o_tx_data <= shift[0];
          end else begin
            cyc       <= cyc - 1'b1;
            o_tx_data <= 1'b0;
          end
        end
        DATA: begin
          o_tx_busy <= 1'b1;
          if (cnt_zero) begin
            cyc <= CNT_LOAD;
            if (bit_idx == 3'd7) begin
              state     <= STOP;
              o_tx_data <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              o_tx_data <= shift[bit_idx + 3'd1];
            end
          end else begin
            cyc       <= cyc - 1'b1;
            o_tx_data <= shift[bit_idx];
          end
        end
        STOP: begin
          if (cnt_zero) begin
            if (stop_avail) begin
              shift     <= pop_data;
              cyc       <= CNT_LOAD;
              state     <= START;
              o_tx_data <= 1'b0;
              o_tx_busy <= 1'b1;
            end else begin
              state     <= IDLE;
              o_tx_data <= 1'b1;
              o_tx_busy <= 1'b0;
            end
          end else begin
            cyc       <= cyc - 1'b1;
            o_tx_data <= 1'b1;
            o_tx_busy <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_tx_data <= 1'b1;
          o_tx_busy <= (count_nxt != '0);
        end
      endcase
    end
  end

endmodule
